// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle for if_id_buffer.
// slave: the buffer's view; master: the fetch/decode environment driving it.
interface if_id_buffer_if #(
  parameter int unsigned PCW = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_instr;
  logic [PCW-1:0] in_pc;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_instr;
  logic [PCW-1:0] out_pc;
  logic [2:0]     out_imm_sel;
  logic           out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm_sel, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm_sel, out_illegal
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID instruction buffer: circular FIFO of instr/PC pairs with the
// immediate-format select and illegal flag decoded at push time and stored
// alongside each entry.
// Optional feature: define IFID_BYPASS_EN to forward the input straight to
// the outputs when the buffer is empty (zero-cycle latency).
module if_id_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PCW   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  if_id_buffer_if.slave              bus,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]    mem_instr [DEPTH];
  logic [PCW-1:0] mem_pc    [DEPTH];
  logic [2:0]     mem_sel   [DEPTH];
  logic           mem_ill   [DEPTH];

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic           not_empty;
  logic           bypass;
  logic           push;
  logic           pop;
  logic [2:0]     in_sel;
  logic           in_ill;

  // Immediate-format select and illegal flag from opcode/funct3.
  function automatic logic [3:0] decode(input logic [6:0] opcode,
                                        input logic [2:0] funct3);
    logic [2:0] sel;
    logic       ill;
    sel = 3'b000;
    ill = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: sel = 3'b000;
      7'b0010011: sel = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b111 : 3'b000;
      7'b0100011: sel = 3'b001;
      7'b1100011: sel = 3'b010;
      7'b0010111: sel = 3'b011;
      7'b1101111: sel = 3'b100;
      7'b0110111: sel = 3'b101;
      7'b0110011, 7'b0001111, 7'b1110011: sel = 3'b000;
      default:    ill = 1'b1;
    endcase
    return {ill, sel};
  endfunction

  assign {in_ill, in_sel} = decode(bus.in_instr[6:0], bus.in_instr[14:12]);

  assign not_empty    = (count != '0);
  assign bus.in_ready = (count != CW'(DEPTH));

`ifdef IFID_BYPASS_EN
  assign bypass = ~not_empty & bus.in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by decode in the same cycle is never stored.
  assign push = bus.in_valid & bus.in_ready & ~flush & ~(bypass & bus.out_ready);
  assign pop  = not_empty & bus.out_ready & ~flush;

  // Head presentation: bypassed input when empty, else the stored head entry.
  always_comb begin
    bus.out_valid   = not_empty | bypass;
    bus.out_instr   = mem_instr[rd_ptr];
    bus.out_pc      = mem_pc[rd_ptr];
    bus.out_imm_sel = not_empty ? mem_sel[rd_ptr] : 3'b000;
    bus.out_illegal = not_empty ? mem_ill[rd_ptr] : 1'b0;
    if (bypass) begin
      bus.out_instr   = bus.in_instr;
      bus.out_pc      = bus.in_pc;
      bus.out_imm_sel = in_sel;
      bus.out_illegal = in_ill;
    end
  end

  // Entry storage; deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.in_instr;
      mem_pc[wr_ptr]    <= bus.in_pc;
      mem_sel[wr_ptr]   <= in_sel;
      mem_ill[wr_ptr]   <= in_ill;
    end
  end

  // Pointers and occupancy; flush outranks push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer; handles both default and IFID_BYPASS_EN builds.
module tb_if_id_buffer;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PCW   = 32;
`ifdef IFID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  if_id_buffer_if #(.PCW(PCW)) bus ();

  if_id_buffer #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] words [5];
  logic [2:0]  sels  [5];
  logic [31:0] q [$];
  int pushed, popped;
  logic take, do_pop, do_push;
  logic [31:0] w;

  initial begin
    words = '{32'h00112223, 32'hFE000EE3, 32'h00001297, 32'h008000EF, 32'h123452B7};
    sels  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_valid", bus.out_valid, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_count", count, 0);
    check("rst_sel", bus.out_imm_sel, 0);
    check("rst_ill", bus.out_illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill with ADDI then SLLI, decode stalled.
    bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h0;
    tick();
    bus.in_instr = 32'h00209113; bus.in_pc = 32'h4;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("full_count", count, 2);
    check("full_ready", bus.in_ready, 0);
    check("head_instr", bus.out_instr, 32'h00500093);
    check("head_pc", bus.out_pc, 0);
    check("head_sel", bus.out_imm_sel, 3'b000);
    tick();
    check("hold_instr", bus.out_instr, 32'h00500093);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pop_instr", bus.out_instr, 32'h00209113);
    check("pop_pc", bus.out_pc, 32'h4);
    check("pop_sel", bus.out_imm_sel, 3'b111);
    check("pop_count", count, 1);

    // Refill to 2 then reset between edges.
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000033; bus.in_pc = 32'h8;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    #1 rst_n = 1'b1;
    tick();

    // Stream of formats with decode always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = words[i]; bus.in_pc = 32'(i * 4);
      if (BYP) begin
        #1;
        check("byp_valid", bus.out_valid, 1);
        check("byp_instr", bus.out_instr, words[i]);
        check("byp_sel", bus.out_imm_sel, sels[i]);
        tick();
        check("byp_count", count, 0);
      end else begin
        tick();
        check("str_valid", bus.out_valid, 1);
        check("str_instr", bus.out_instr, words[i]);
        check("str_sel", bus.out_imm_sel, sels[i]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    check("str_drain_count", count, 0);
    check("str_drain_valid", bus.out_valid, 0);

    // Unrecognised opcode.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000007F; bus.in_pc = 32'h40;
    tick();
    bus.in_valid = 1'b0;
    check("ill_flag", bus.out_illegal, 1);
    check("ill_sel", bus.out_imm_sel, 3'b000);
    check("ill_count", count, 1);

    // Flush with count=1 and a same-cycle push.
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000013; bus.in_pc = 32'h44;
    flush = 1'b1;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("fl_count", count, 0);
    check("fl_valid", bus.out_valid, 0);
    check("fl_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    check("fl_dropped", bus.out_valid, 0);

    // Wrap test: DEPTH*3 words, out_ready toggling, queue model.
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 40 && popped < 3 * DEPTH; cyc++) begin
      w = 32'h00000013 | (32'(pushed + 1) << 20);
      bus.in_valid  = (pushed < 3 * DEPTH);
      bus.in_instr  = w;
      bus.in_pc     = 32'(pushed * 4);
      bus.out_ready = (cyc % 2 == 1);
      #1;
      check("wr_count", count, q.size());
      check("wr_ready", bus.in_ready, q.size() != DEPTH);
      check("wr_valid", bus.out_valid, (q.size() > 0) || (BYP && bus.in_valid));
      if (q.size() > 0) check("wr_order", bus.out_instr, q[0]);
      else if (BYP && bus.in_valid) check("wr_byp", bus.out_instr, w);
      take    = BYP && q.size() == 0 && bus.in_valid && bus.out_ready;
      do_pop  = q.size() > 0 && bus.out_ready;
      do_push = bus.in_valid && q.size() < DEPTH && !take;
      tick();
      if (do_pop) begin void'(q.pop_front()); popped++; end
      if (take) popped++;
      if (do_push) q.push_back(w);
      if (do_push || take) pushed++;
    end
    bus.in_valid = 1'b0;
    check("wr_popped", popped, 3 * DEPTH);
    check("wr_final_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
